// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-requester round-robin arbiter and sequencer in front of the shared
// execute-stage ALU. One request is granted per cycle and registered into an
// issue stage (p1) that drives the ALU. The combinational ALU result is then
// captured into a response stage (p2) that supports consumer backpressure.
// A synchronous flush drops everything in flight.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous clear of all in-flight operations
//   reqN_valid / reqN_ready    request handshake, N = 0, 1
//   reqN_op, reqN_a, reqN_b    request payload (opcode, SrcA, SrcB)
//   alu_srca, alu_srcb         operands to the ALU (0 when the issue stage is empty)
//   alu_operation              opcode to the ALU (0 when the issue stage is empty)
//   alu_result                 combinational result returned by the ALU
//   rsp_valid / rsp_ready      response handshake
//   rsp_id                     index of the requester that owns the response
//   rsp_result                 captured ALU result
//   busy                       any stage occupied
module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic [DATA_WIDTH-1:0]    req0_a,
    input  logic [DATA_WIDTH-1:0]    req0_b,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    input  logic [DATA_WIDTH-1:0]    req1_a,
    input  logic [DATA_WIDTH-1:0]    req1_b,

    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]    alu_result,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [DATA_WIDTH-1:0]    rsp_result,

    output logic                     busy
);

    // Issue stage
    logic                     vld_p1;
    logic                     id_p1;
    logic [OPCODE_LENGTH-1:0] op_p1;
    logic [DATA_WIDTH-1:0]    a_p1;
    logic [DATA_WIDTH-1:0]    b_p1;

    // Response stage
    logic                     vld_p2;
    logic                     id_p2;
    logic [DATA_WIDTH-1:0]    res_p2;

    // Requester granted most recently; resets to 1 so req0 wins first contention.
    logic                     rr_last;

    logic                     gnt_vld;
    logic                     gnt_id;
    logic                     p2_free;
    logic                     p1_free;
    logic                     accept;
    logic                     advance;
    logic                     drain;

    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = ~rr_last;
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
    end

    assign p2_free = ~vld_p2 | rsp_ready;
    assign p1_free = ~vld_p1 | p2_free;

    // Ready is blocked during flush so no new work slips in while the pipe is cleared.
    assign req0_ready = p1_free & ~flush & gnt_vld & ~gnt_id;
    assign req1_ready = p1_free & ~flush & gnt_vld &  gnt_id;

    assign accept  = p1_free & ~flush & gnt_vld;
    assign advance = vld_p1 & p2_free;
    assign drain   = vld_p2 & rsp_ready;

    // ---- stage p0 -> p1: load the granted request into the issue stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            id_p1   <= 1'b0;
            op_p1   <= '0;
            a_p1    <= '0;
            b_p1    <= '0;
            rr_last <= 1'b1;
        end else if (flush) begin
            vld_p1  <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            id_p1   <= gnt_id;
            op_p1   <= gnt_id ? req1_op : req0_op;
            a_p1    <= gnt_id ? req1_a  : req0_a;
            b_p1    <= gnt_id ? req1_b  : req0_b;
            rr_last <= gnt_id;
        end else if (advance) begin
            vld_p1  <= 1'b0;
        end
    end

    // ---- stage p1 -> p2: capture the ALU result into the response stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            id_p2  <= 1'b0;
            res_p2 <= '0;
        end else if (flush) begin
            vld_p2 <= 1'b0;
        end else if (advance) begin
            vld_p2 <= 1'b1;
            id_p2  <= id_p1;
            res_p2 <= alu_result;
        end else if (drain) begin
            vld_p2 <= 1'b0;
        end
    end

    // The ALU sees zeros whenever the issue stage is empty.
    assign alu_srca      = vld_p1 ? a_p1  : '0;
    assign alu_srcb      = vld_p1 ? b_p1  : '0;
    assign alu_operation = vld_p1 ? op_p1 : '0;

    assign rsp_valid  = vld_p2;
    assign rsp_id     = id_p2;
    assign rsp_result = res_p2;
    assign busy       = vld_p1 | vld_p2;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. A small behavioural ALU closes the loop
// on alu_* / alu_result. The reference model is a transaction queue: each
// accepted request is appended with its expected result, the head is the
// response once it has reached the response register, and readiness is
// derived from how many transactions occupy the two slots.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [OW-1:0] req0_op = '0, req1_op = '0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [DW-1:0] alu_srca, alu_srcb;
    logic [OW-1:0] alu_operation;
    logic [DW-1:0] alu_result;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_id;
    logic [DW-1:0] rsp_result;
    logic          busy;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_operation(alu_operation),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_alu(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd10:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    always_comb alu_result = ref_alu(alu_operation, alu_srca, alu_srcb);

    // ---------------- reference model ----------------
    typedef struct {
        bit            id;
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
    } item_t;

    item_t q[$];
    bit    in_s2  = 1'b0;   // head of q sits in the response register
    bit    m_last = 1'b1;

    bit            e_r0, e_r1, e_rv, e_busy, e_id, e_s2f;
    int            e_s1b;
    logic [DW-1:0] e_res, e_a, e_b;
    logic [OW-1:0] e_op;

    task automatic model_eval();
        bit s1f, has, g;
        e_s1b = q.size() - (in_s2 ? 1 : 0);
        e_s2f = !in_s2 || rsp_ready;
        s1f   = (e_s1b == 0) || e_s2f;
        has   = req0_valid || req1_valid;
        if (req0_valid && req1_valid) g = m_last ? 1'b0 : 1'b1;
        else                          g = req1_valid;
        e_r0   = s1f && !flush && has && (g == 1'b0);
        e_r1   = s1f && !flush && has && (g == 1'b1);
        e_rv   = in_s2;
        e_busy = (q.size() != 0);
        e_id   = in_s2 ? q[0].id  : 1'b0;
        e_res  = in_s2 ? q[0].res : '0;
        if (e_s1b > 0) begin
            e_a  = q[q.size()-1].a;
            e_b  = q[q.size()-1].b;
            e_op = q[q.size()-1].op;
        end else begin
            e_a = '0; e_b = '0; e_op = '0;
        end
    endtask

    task automatic model_reset();
        q.delete();
        in_s2  = 1'b0;
        m_last = 1'b1;
    endtask

    // Advance one clock edge; the model follows using the inputs present at the edge.
    task automatic tick();
        bit    fl, s2f, drain, acc, gid;
        int    s1b;
        item_t it;
        model_eval();
        fl    = flush;
        s2f   = e_s2f;
        s1b   = e_s1b;
        drain = in_s2 && rsp_ready;
        acc   = e_r0 || e_r1;
        gid   = e_r1;
        it.id  = gid;
        it.op  = gid ? req1_op : req0_op;
        it.a   = gid ? req1_a  : req0_a;
        it.b   = gid ? req1_b  : req0_b;
        it.res = ref_alu(it.op, it.a, it.b);
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            in_s2 = 1'b0;
        end else begin
            if (drain) q.delete(0);
            if (s1b > 0 && s2f) in_s2 = 1'b1;
            else if (drain)     in_s2 = 1'b0;
            if (acc) begin
                q.push_back(it);
                m_last = gid;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%b want=0", rsp_id); end
        total++; if (rsp_result !== 32'd0) begin bad++; $display("FAIL reset_rsp_result got=%h want=0", rsp_result); end
        total++; if (alu_srca !== 32'd0 || alu_srcb !== 32'd0 || alu_operation !== 4'd0) begin
            bad++; $display("FAIL reset_alu got=%h/%h/%h want=0/0/0", alu_srca, alu_srcb, alu_operation); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL reset_idle_ready got=%b%b want=00", req0_ready, req1_ready); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL reset_first_grant got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        total++; if (alu_srca !== 32'd5 || alu_srcb !== 32'd7 || alu_operation !== 4'd0) begin
            bad++; $display("FAIL single_alu_drive got=%h/%h/%h want=5/7/0", alu_srca, alu_srcb, alu_operation); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp got=%b want=0", rsp_valid); end
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd12) begin
            bad++; $display("FAIL single_rsp got v=%b id=%b res=%0d want v=1 id=0 res=12", rsp_valid, rsp_id, rsp_result); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        tick();
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_idle got busy=%b v=%b want 0/0", busy, rsp_valid); end
    endtask

    task automatic test_wrap();
        logic [OW-1:0] ops [2];
        logic [DW-1:0] as  [2];
        logic [DW-1:0] want[2];
        ops[0] = 4'b0001; as[0] = 32'd0;          want[0] = 32'hFFFF_FFFF;
        ops[1] = 4'b1010; as[1] = 32'hFFFF_FFFF;  want[1] = 32'd1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req1_valid = 1'b1; req1_op = ops[i]; req1_a = as[i]; req1_b = 32'd1;
            #1;
            total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready[%0d] got=%b want=1", i, req1_ready); end
            tick();
            req1_valid = 1'b0;
            tick();
            total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== want[i]) begin
                bad++; $display("FAIL wrap_rsp[%0d] got v=%b id=%b res=%h want v=1 id=1 res=%h",
                                i, rsp_valid, rsp_id, rsp_result, want[i]); end
            tick();
        end
    endtask

    task automatic test_contention();
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd100; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'd100; req1_b = 32'd1;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                bad++; $display("FAIL contention_grant[%0d] got r0=%b r1=%b want grant=%0d", i, req0_ready, req1_ready, i % 2); end
            if (i >= 2) begin
                total++; if (rsp_valid !== 1'b1 || rsp_id !== ((i - 2) % 2 == 1)
                             || rsp_result !== (((i - 2) % 2 == 0) ? 32'd101 : 32'd99)) begin
                    bad++; $display("FAIL contention_rsp[%0d] got v=%b id=%b res=%0d want v=1 id=%0d",
                                    i, rsp_valid, rsp_id, rsp_result, (i - 2) % 2); end
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_backpressure();
        int k = 0;
        rsp_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd10 + k; req0_b = k;
            #1;
            total++; if (req0_ready !== (j < 2)) begin
                bad++; $display("FAIL bp_ready[%0d] got=%b want=%0d", j, req0_ready, (j < 2)); end
            if (j >= 2) begin
                total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd10) begin
                    bad++; $display("FAIL bp_hold[%0d] got v=%b id=%b res=%0d want v=1 id=0 res=10", j, rsp_valid, rsp_id, rsp_result); end
            end
            if (j < 2) k++;
            tick();
        end
        req0_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd12) begin
            bad++; $display("FAIL bp_second got v=%b res=%0d want v=1 res=12", rsp_valid, rsp_result); end
        tick();
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL bp_drained got v=%b busy=%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd1; req1_b = 32'd2;
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd3; req0_b = 32'd4;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL flush_fill_ready got=%b want=1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd3 || alu_srca !== 32'd3) begin
            bad++; $display("FAIL flush_full got v=%b res=%0d srca=%0d want v=1 res=3 srca=3", rsp_valid, rsp_result, alu_srca); end
        flush = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL flush_ready got r0=%b r1=%b want 0/0", req0_ready, req1_ready); end
        tick();
        flush = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_srca !== 32'd0) begin
            bad++; $display("FAIL flush_clear got v=%b busy=%b srca=%0d want 0/0/0", rsp_valid, busy, alu_srca); end
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            bad++; $display("FAIL flush_rr got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset_midstream();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'h55; req0_b = 32'd1;
        tick();
        tick();
        req0_valid = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h56) begin
            bad++; $display("FAIL mid_pre got v=%b res=%h want v=1 res=56", rsp_valid, rsp_result); end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_rsp_clear got v=%b res=%h busy=%b want 0/0/0", rsp_valid, rsp_result, busy); end
        total++; if (alu_srca !== 32'd0 || alu_srcb !== 32'd0 || alu_operation !== 4'd0) begin
            bad++; $display("FAIL mid_alu_clear got %h/%h/%h want 0/0/0", alu_srca, alu_srcb, alu_operation); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL mid_first_grant got r0=%b r1=%b want 1/0", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_random();
        bit acc0 = 1'b0, acc1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op = OW'($urandom_range(0, 15)); req0_a = $urandom; req0_b = $urandom;
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op = OW'($urandom_range(0, 15)); req1_a = $urandom; req1_b = $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            #1;
            model_eval();
            total++; if (req0_ready !== e_r0 || req1_ready !== e_r1) begin
                bad++; $display("FAIL rnd_ready c=%0d got=%b%b want=%b%b", c, req0_ready, req1_ready, e_r0, e_r1); end
            total++; if (rsp_valid !== e_rv || busy !== e_busy) begin
                bad++; $display("FAIL rnd_valid c=%0d got v=%b busy=%b want v=%b busy=%b", c, rsp_valid, busy, e_rv, e_busy); end
            if (e_rv) begin
                total++; if (rsp_id !== e_id || rsp_result !== e_res) begin
                    bad++; $display("FAIL rnd_rsp c=%0d got id=%b res=%h want id=%b res=%h", c, rsp_id, rsp_result, e_id, e_res); end
            end
            total++; if (alu_srca !== e_a || alu_srcb !== e_b || alu_operation !== e_op) begin
                bad++; $display("FAIL rnd_alu c=%0d got %h/%h/%h want %h/%h/%h", c, alu_srca, alu_srcb, alu_operation, e_a, e_b, e_op); end
            acc0 = e_r0;
            acc1 = e_r1;
            tick();
        end
        flush = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick(); tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_final_busy got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
